// File: rtl/temp_mon_pkg.sv
// temp_mon_pkg: width derivations and default thresholds shared by the
// temperature monitor blocks.
package temp_mon_pkg;
    localparam int DEFAULT_LOW_THR = 35;
    localparam int DEFAULT_HIGH_THR = 39;
    function automatic int tempWidth(input int baseW, input int coefW, input int sensorW);
        return ((baseW > coefW + sensorW) ? baseW : coefW + sensorW) + 1;
    endfunction
    function automatic int chWidth(input int numCh);
        return (numCh > 1) ? $clog2(numCh) : 1;
    endfunction
endpackage

// File: rtl/temp_abnormality_monitor_debounce.sv
// temp_ch_debounce: per-channel disagreement counter and alarm bit.
// With TEMP_MON_ALARM_LATCH_EN defined a raised alarm is sticky until clear.
module temp_ch_debounce #(
    parameter int DEBOUNCE = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic update,
    input  logic abnormal,
    output logic alarm,
    output logic alarmNext
);
    logic [3:0] cnt, cntBase, cntInc, cntNext;
    logic alarmBase, differ, toggle;
    // clear is folded in first so a coincident sample sees a fresh channel
    always_comb begin
        alarmBase = clear ? 1'b0 : alarm;
        cntBase = clear ? 4'd0 : cnt;
        cntInc = cntBase + 4'd1;
`ifdef TEMP_MON_ALARM_LATCH_EN
        differ = abnormal && !alarmBase;
`else
        differ = abnormal != alarmBase;
`endif
        toggle = update && differ && cntInc == 4'(DEBOUNCE);
        alarmNext = toggle ? !alarmBase : alarmBase;
        cntNext = !update ? cntBase : (differ && !toggle) ? cntInc : 4'd0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm <= 1'b0;
            cnt <= 4'd0;
        end else begin
            alarm <= alarmNext;
            cnt <= cntNext;
        end
    end
endmodule

// File: rtl/temp_abnormality_monitor.sv
// temp_abnormality_monitor: two-stage temperature compute and per-channel
// debounced range alarm. Optional sticky alarms via TEMP_MON_ALARM_LATCH_EN.
module temp_abnormality_monitor import temp_mon_pkg::*; #(
    parameter int NUM_CH = 4,
    parameter int BASE_W = 8,
    parameter int COEF_W = 4,
    parameter int SENSOR_W = 4,
    parameter int DEBOUNCE = 3,
    localparam int TEMP_W = tempWidth(BASE_W, COEF_W, SENSOR_W),
    localparam int CH_W = chWidth(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BASE_W-1:0]   factoryBaseTemp,
    input  logic [COEF_W-1:0]   factoryTempCoef,
    input  logic [TEMP_W-1:0]   lowThr,
    input  logic [TEMP_W-1:0]   highThr,
    input  logic                sampleValid,
    input  logic [CH_W-1:0]     sampleCh,
    input  logic [SENSOR_W-1:0] tempSensorValue,
    input  logic                clearAlarm,
    output logic                tempValid,
    output logic [TEMP_W-1:0]   tempOut,
    output logic [CH_W-1:0]     tempCh,
    output logic [NUM_CH-1:0]   temperatureAbnormality,
    output logic                anyAbnormal,
    output logic                chIdxErr
);
    logic [TEMP_W-1:0] tempCalc;
    logic [NUM_CH-1:0] alarmNext;
    logic chOk, abnormal;
    always_comb begin
        tempCalc = TEMP_W'(factoryBaseTemp) + TEMP_W'(factoryTempCoef) * TEMP_W'(tempSensorValue);
        chOk = int'(sampleCh) < NUM_CH;
        abnormal = tempOut < lowThr || tempOut > highThr;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tempValid <= 1'b0;
            tempOut <= '0;
            tempCh <= '0;
            chIdxErr <= 1'b0;
            anyAbnormal <= 1'b0;
        end else begin
            tempValid <= sampleValid && chOk;
            chIdxErr <= sampleValid && !chOk;
            anyAbnormal <= |alarmNext;
            if (sampleValid && chOk) begin
                tempOut <= tempCalc;
                tempCh <= sampleCh;
            end
        end
    end
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        temp_ch_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
            .clk(clk),
            .rst_n(rst_n),
            .clear(clearAlarm),
            .update(tempValid && tempCh == CH_W'(c)),
            .abnormal(abnormal),
            .alarm(temperatureAbnormality[c]),
            .alarmNext(alarmNext[c])
        );
    end
endmodule

// File: tb/tb_temp_abnormality_monitor.sv
// tb_temp_abnormality_monitor: randomized stimulus against a behavioural model,
// plus directed literal checks; three channels so an out-of-range index exists.
module tb_temp_abnormality_monitor;
    import temp_mon_pkg::*;
    localparam int NUM_CH = 3;
    localparam int DEBOUNCE = 3;
`ifdef TEMP_MON_ALARM_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] factoryBaseTemp = '0;
    logic [3:0] factoryTempCoef = '0;
    logic [8:0] lowThr = 9'(DEFAULT_LOW_THR);
    logic [8:0] highThr = 9'(DEFAULT_HIGH_THR);
    logic sampleValid = 1'b0;
    logic [1:0] sampleCh = '0;
    logic [3:0] tempSensorValue = '0;
    logic clearAlarm = 1'b0;
    logic tempValid, anyAbnormal, chIdxErr;
    logic [8:0] tempOut;
    logic [1:0] tempCh;
    logic [NUM_CH-1:0] temperatureAbnormality;

    temp_abnormality_monitor #(.NUM_CH(NUM_CH), .BASE_W(8), .COEF_W(4), .SENSOR_W(4), .DEBOUNCE(DEBOUNCE)) dut (
        .clk(clk), .rst_n(rst_n),
        .factoryBaseTemp(factoryBaseTemp), .factoryTempCoef(factoryTempCoef),
        .lowThr(lowThr), .highThr(highThr),
        .sampleValid(sampleValid), .sampleCh(sampleCh), .tempSensorValue(tempSensorValue),
        .clearAlarm(clearAlarm),
        .tempValid(tempValid), .tempOut(tempOut), .tempCh(tempCh),
        .temperatureAbnormality(temperatureAbnormality), .anyAbnormal(anyAbnormal), .chIdxErr(chIdxErr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    function automatic void chk(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    // Model: per-channel alarm bits and disagreement counts.
    typedef struct packed {
        logic [NUM_CH-1:0] a;
        logic [NUM_CH-1:0][3:0] c;
    } chState_t;

    function automatic chState_t nextState(chState_t s, bit clr, bit vld, int t, int ch, int lo, int hi);
        chState_t n = clr ? '0 : s;
        bit ab = t < lo || t > hi;
        if (vld) begin
            if (ab != n.a[ch] && !(LATCH && n.a[ch])) begin
                n.c[ch] = n.c[ch] + 4'd1;
                if (int'(n.c[ch]) == DEBOUNCE) begin
                    n.a[ch] = !n.a[ch];
                    n.c[ch] = 4'd0;
                end
            end else n.c[ch] = 4'd0;
        end
        return n;
    endfunction

    chState_t mS;
    bit mValid, mErr;
    int mTemp, mCh;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mS <= '0;
            mValid <= 1'b0;
            mErr <= 1'b0;
            mTemp <= 0;
            mCh <= 0;
        end else begin
            mS <= nextState(mS, clearAlarm, mValid, mTemp, mCh, int'(lowThr), int'(highThr));
            mValid <= sampleValid && int'(sampleCh) < NUM_CH;
            mErr <= sampleValid && int'(sampleCh) >= NUM_CH;
            if (sampleValid && int'(sampleCh) < NUM_CH) begin
                mTemp <= int'(factoryBaseTemp) + int'(factoryTempCoef) * int'(tempSensorValue);
                mCh <= int'(sampleCh);
            end
        end
    end

    always @(negedge clk) begin
        chk("tempValid", int'(tempValid), int'(mValid));
        chk("chIdxErr", int'(chIdxErr), int'(mErr));
        if (mValid) begin
            chk("tempOut", int'(tempOut), mTemp);
            chk("tempCh", int'(tempCh), mCh);
        end
        chk("alarms", int'(temperatureAbnormality), int'(mS.a));
        chk("anyAbnormal", int'(anyAbnormal), int'(|mS.a));
    end

    task automatic send(input int ch, input int base, input int coef, input int sens);
        sampleCh = 2'(ch);
        factoryBaseTemp = 8'(base);
        factoryTempCoef = 4'(coef);
        tempSensorValue = 4'(sens);
        sampleValid = 1'b1;
        @(negedge clk);
        sampleValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        idle(2);
        chk("rst_tempValid", int'(tempValid), 0);
        chk("rst_tempOut", int'(tempOut), 0);
        chk("rst_alarms", int'(temperatureAbnormality), 0);
        chk("rst_any", int'(anyAbnormal), 0);
        chk("rst_err", int'(chIdxErr), 0);
        rst_n = 1'b1;
        // 17 + 8*2 = 33, below 35
        send(0, 17, 8, 2);
        chk("first_temp", int'(tempOut), 33);
        chk("first_valid", int'(tempValid), 1);
        send(0, 17, 8, 2);
        send(0, 17, 8, 2);
        chk("alarm_not_yet", int'(temperatureAbnormality[0]), 0);
        idle(1);
        chk("alarm_set", int'(temperatureAbnormality[0]), 1);
        chk("any_set", int'(anyAbnormal), 1);
        // 20 + 16 = 36, in range
        send(0, 20, 8, 2);
        send(0, 20, 8, 2);
        send(0, 20, 8, 2);
        idle(1);
        chk("alarm_after_normal", int'(temperatureAbnormality[0]), LATCH ? 1 : 0);
        clearAlarm = 1'b1;
        idle(1);
        clearAlarm = 1'b0;
        chk("alarm_cleared", int'(temperatureAbnormality[0]), 0);
        send(1, 17, 8, 2);
        send(1, 20, 8, 2);
        send(1, 17, 8, 2);
        send(1, 17, 8, 2);
        idle(1);
        chk("interrupted_run", int'(temperatureAbnormality), 0);
        send(3, 17, 8, 2);
        chk("idx_err_pulse", int'(chIdxErr), 1);
        chk("idx_err_novalid", int'(tempValid), 0);
        idle(1);
        chk("idx_err_end", int'(chIdxErr), 0);
        chk("idx_err_nostate", int'(temperatureAbnormality), 0);
        send(2, 255, 15, 15);
        chk("max_temp", int'(tempOut), 480);
        send(2, 255, 15, 15);
        send(2, 255, 15, 15);
        clearAlarm = 1'b1;
        idle(1);
        clearAlarm = 1'b0;
        chk("clear_coincident", int'(temperatureAbnormality[2]), 0);
        send(2, 255, 15, 15);
        idle(1);
        chk("count_two", int'(temperatureAbnormality[2]), 0);
        send(2, 255, 15, 15);
        idle(1);
        chk("count_three", int'(temperatureAbnormality[2]), 1);
        sampleValid = 1'b1;
        sampleCh = 2'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", int'(tempValid), 0);
        chk("async_temp", int'(tempOut), 0);
        chk("async_alarms", int'(temperatureAbnormality), 0);
        chk("async_any", int'(anyAbnormal), 0);
        sampleValid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 48 == 0) begin
                factoryBaseTemp = 8'($urandom_range(0, 255));
                factoryTempCoef = 4'($urandom_range(0, 15));
                lowThr = 9'($urandom_range(0, 250));
                highThr = lowThr + 9'($urandom_range(0, 200));
                if ($urandom_range(0, 7) == 0) {lowThr, highThr} = {highThr, lowThr};
            end
            sampleValid = $urandom_range(0, 3) != 0;
            sampleCh = 2'($urandom_range(0, 3));
            tempSensorValue = 4'($urandom_range(0, 15));
            clearAlarm = $urandom_range(0, 63) == 0;
            @(negedge clk);
        end
        sampleValid = 1'b0;
        clearAlarm = 1'b0;
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/temp_abnormality_monitor.md
TEMP_ABNORMALITY_MONITOR -- requirements
Module: temp_abnormality_monitor

Interface
REQ-001 Parameter NUM_CH, default 4: number of monitored sensor channels, 1..16.
REQ-002 Parameter BASE_W, default 8: factory base temperature width.
REQ-003 Parameter COEF_W, default 4: factory temperature coefficient width.
REQ-004 Parameter SENSOR_W, default 4: raw sensor value width.
REQ-005 Parameter DEBOUNCE, default 3: consecutive disagreeing samples needed to toggle an alarm, 1..15.
REQ-006 Derived constant TEMP_W = max(BASE_W, COEF_W+SENSOR_W)+1; CH_W = max(1, clog2(NUM_CH)).
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 factoryBaseTemp  in  BASE_W  unsigned base temperature, shared by all channels.
REQ-010 factoryTempCoef  in  COEF_W  unsigned per-LSB coefficient, shared.
REQ-011 lowThr / highThr  in  TEMP_W each  inclusive normal-range bounds.
REQ-012 sampleValid  in  1  sample present this cycle.
REQ-013 sampleCh  in  CH_W  channel index of the sample.
REQ-014 tempSensorValue  in  SENSOR_W  raw sensor reading.
REQ-015 clearAlarm  in  1  one-cycle pulse; clears all alarms and counters.
REQ-016 tempValid  out  1  tempOut and tempCh valid.
REQ-017 tempOut  out  TEMP_W  computed temperature.  tempCh  out  CH_W  its channel.
REQ-018 temperatureAbnormality  out  NUM_CH  per-channel registered alarm.
REQ-019 anyAbnormal  out  1  OR of all alarm bits, registered.
REQ-020 chIdxErr  out  1  one-cycle pulse: sample with sampleCh >= NUM_CH dropped.

Function
REQ-021 Temperature SHALL be factoryBaseTemp + factoryTempCoef*tempSensorValue, unsigned, computed at TEMP_W with no overflow or truncation.
REQ-022 Stage 1: a sample accepted in cycle N SHALL produce tempValid=1 with tempOut/tempCh in cycle N+1; no backpressure, one sample per cycle sustained.
REQ-023 Stage 2: a sample SHALL be abnormal iff tempOut < lowThr or tempOut > highThr; if lowThr > highThr every sample SHALL be abnormal.
REQ-024 Each channel SHALL hold a disagreement counter (0..DEBOUNCE) and an alarm bit; a stage-2 sample whose abnormal flag differs from the channel's alarm SHALL increment the counter, and a matching sample SHALL zero it.
REQ-025 When the increment brings the counter to DEBOUNCE, the alarm SHALL toggle and the counter SHALL zero in the same update; the alarm is visible in cycle N+2.
REQ-026 Only the channel named by tempCh SHALL update; other channels SHALL hold state.
REQ-027 sampleCh >= NUM_CH: sample SHALL be dropped, tempValid SHALL stay 0, and chIdxErr SHALL pulse in cycle N+1.
REQ-028 clearAlarm coincident with a stage-2 update: clear SHALL apply first, then the sample SHALL be evaluated against alarm=0, counter=0.
REQ-029 Threshold or factory inputs changing mid-stream SHALL affect only samples entering the corresponding stage on or after the change.

Reset
REQ-030 rst_n low SHALL asynchronously force tempValid=0, tempOut=0, tempCh=0, all alarms=0, anyAbnormal=0, chIdxErr=0, all counters=0; in-flight samples are discarded.
REQ-031 The first sample SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-032 Macro TEMP_MON_ALARM_LATCH_EN defined: an asserted alarm SHALL stay set until clearAlarm or reset; normal samples SHALL not increment its counter.
REQ-033 Macro undefined: alarms SHALL self-clear per REQ-024/025 (symmetric hysteresis).

Structure
REQ-034 Package temp_mon_pkg SHALL hold TEMP_W/CH_W derivation functions and the default threshold constants (35, 39).
REQ-035 Per-channel counter plus alarm SHALL be sub-module temp_ch_debounce, instantiated NUM_CH times by generate.

Verification
REQ-036 base=17, coef=8, sensor=2, ch0, thr 35..39 -> tempOut=33 at N+1; after 3 samples temperatureAbnormality[0]=1 at the third sample's N+2.
REQ-037 Channel 0 alarmed, then 3 samples sensor=2 with base=20 (temp 36) -> alarm clears (macro undefined); stays set (macro defined) until clearAlarm.
REQ-038 Abnormal, normal, abnormal, abnormal on ch1 -> no alarm (counter reset by the normal sample).
REQ-039 NUM_CH=3, sampleCh=3 -> chIdxErr pulse, no tempValid, no state change on any channel.
REQ-040 base=255, coef=15, sensor=15 -> tempOut=480 (9 bits); clearAlarm coincident with an abnormal sample -> counter=1, alarm 0; rst_n pulsed mid-stream -> all outputs 0 immediately.
